// File: rtl/fp_div.sv
// fp_div: multi-cycle IEEE 754 binary floating-point divider.
// Restoring radix-2 significand division, one quotient bit per clock.
// Results are truncated toward zero. No rounding and no sticky bit.
//
// Handshake: start is sampled only while the FSM is in IDLE. busy is high
// from the cycle after the accepting edge until the result cycle. done is a
// one-cycle pulse in the cycle where q/qFlags take the new result (busy is
// already low then). start is ignored while busy, and nothing is queued.

package fp_div_pkg;
  // One-hot class flag bit positions
  localparam int F_NORMAL    = 0;
  localparam int F_SUBNORMAL = 1;
  localparam int F_ZERO      = 2;
  localparam int F_INFINITY  = 3;
  localparam int F_QNAN      = 4;
  localparam int F_SNAN      = 5;
  localparam int LAST_FLAG   = 6;
endpackage

module fp_div
  import fp_div_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NEXP+NSIG:0]        a,
  input  logic [NEXP+NSIG:0]        b,
  output logic                      busy,
  output logic                      done,
  output logic [NEXP+NSIG:0]        q,
  output logic [LAST_FLAG-1:0]      qFlags,
  output logic [1:0]                dbg_state
);

  localparam int W    = NEXP + NSIG + 1;
  localparam int EW   = NEXP + 2;
  localparam int CW   = $clog2(NSIG + 2);
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int EMIN = 1 - BIAS;
  localparam int EMAX = BIAS;

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN_E = EW'(EMIN);
  localparam logic signed [EW-1:0] EMAX_E = EW'(EMAX);
  localparam logic signed [EW-1:0] ZLIM_E = EW'(EMIN - NSIG);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [CW-1:0]        CNT_INIT = CW'(NSIG + 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // Operand classification (one-hot)
  function automatic logic [LAST_FLAG-1:0] classify(input logic [W-1:0] x);
    logic [NEXP-1:0] e;
    logic [NSIG-1:0] f;
    e = x[W-2:NSIG];
    f = x[NSIG-1:0];
    classify = '0;
    if (&e) begin
      if (f == '0)        classify[F_INFINITY] = 1'b1;
      else if (f[NSIG-1]) classify[F_QNAN]     = 1'b1;
      else                classify[F_SNAN]     = 1'b1;
    end else if (e == '0) begin
      if (f == '0) classify[F_ZERO]      = 1'b1;
      else         classify[F_SUBNORMAL] = 1'b1;
    end else begin
      classify[F_NORMAL] = 1'b1;
    end
  endfunction

  // Unbiased exponent; subnormals sit at EMIN with a zero hidden bit
  function automatic logic signed [EW-1:0] unb_exp(input logic [W-1:0] x);
    if (x[W-2:NSIG] == '0) return EMIN_E;
    return $signed({2'b00, x[W-2:NSIG]}) - BIAS_E;
  endfunction

  // Significand with the hidden bit made explicit
  function automatic logic [NSIG:0] full_sig(input logic [W-1:0] x);
    return {(x[W-2:NSIG] != '0), x[NSIG-1:0]};
  endfunction

  logic [1:0]              state_r;
  logic [W-1:0]            a_raw, b_raw;
  logic [LAST_FLAG-1:0]    a_flags, b_flags;
  logic signed [EW-1:0]    a_exp, b_exp;
  logic [NSIG:0]           a_sig, b_sig;
  logic                    sign_r;
  logic signed [EW-1:0]    exp_r;
  logic [NSIG+1:0]         rem;
  logic [NSIG+1:0]         quo;
  logic [CW-1:0]           cnt;

  logic [NSIG+1:0]         trial;
  logic [NSIG+1:0]         rem_next;

  logic                    special_hit;
  logic [W-1:0]            special_q;
  logic [LAST_FLAG-1:0]    special_flags;

  logic signed [EW-1:0]    t_exp;
  logic [NSIG:0]           t_sig;
  logic [EW-1:0]           sub_sh;
  logic [NSIG:0]           sub_sig;
  logic signed [EW-1:0]    biased;
  logic [W-1:0]            arith_q;
  logic [LAST_FLAG-1:0]    arith_flags;

  assign dbg_state = state_r;

  // Restoring step: the trial difference fits NSIG+2 bits because rem < 2*b_sig
  assign trial    = rem - {1'b0, b_sig};
  assign rem_next = trial[NSIG+1] ? rem : trial;

  // Special-case resolution in priority order from the latched classes
  always_comb begin
    special_hit   = 1'b1;
    special_q     = '0;
    special_flags = '0;
    if (a_flags[F_SNAN]) begin
      special_q = a_raw;
      special_flags[F_SNAN] = 1'b1;
    end else if (b_flags[F_SNAN]) begin
      special_q = b_raw;
      special_flags[F_SNAN] = 1'b1;
    end else if (a_flags[F_QNAN]) begin
      special_q = a_raw;
      special_flags[F_QNAN] = 1'b1;
    end else if (b_flags[F_QNAN]) begin
      special_q = b_raw;
      special_flags[F_QNAN] = 1'b1;
    end else if ((a_flags[F_INFINITY] && b_flags[F_INFINITY]) ||
                 (a_flags[F_ZERO] && b_flags[F_ZERO])) begin
      special_q = {sign_r, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
      special_flags[F_QNAN] = 1'b1;
    end else if (a_flags[F_INFINITY] || b_flags[F_ZERO]) begin
      special_q = {sign_r, {NEXP{1'b1}}, {NSIG{1'b0}}};
      special_flags[F_INFINITY] = 1'b1;
    end else if (a_flags[F_ZERO] || b_flags[F_INFINITY]) begin
      special_q = {sign_r, {(W-1){1'b0}}};
      special_flags[F_ZERO] = 1'b1;
    end else begin
      special_hit = 1'b0;
    end
  end

  // Quotient normalization, truncation and range check
  always_comb begin
    t_exp       = quo[NSIG+1] ? exp_r : (exp_r - ONE_E);
    t_sig       = quo[NSIG+1] ? quo[NSIG+1:1] : quo[NSIG:0];
    sub_sh      = EMIN_E - t_exp;
    sub_sig     = t_sig >> sub_sh;
    biased      = t_exp + BIAS_E;
    arith_q     = '0;
    arith_flags = '0;
    if (t_exp < ZLIM_E) begin
      arith_q = {sign_r, {(W-1){1'b0}}};
      arith_flags[F_ZERO] = 1'b1;
    end else if (t_exp < EMIN_E) begin
      arith_q = {sign_r, {NEXP{1'b0}}, sub_sig[NSIG-1:0]};
      arith_flags[F_SUBNORMAL] = 1'b1;
    end else if (t_exp > EMAX_E) begin
      arith_q = {sign_r, {NEXP{1'b1}}, {NSIG{1'b0}}};
      arith_flags[F_INFINITY] = 1'b1;
    end else begin
      arith_q = {sign_r, biased[NEXP-1:0], t_sig[NSIG-1:0]};
      arith_flags[F_NORMAL] = 1'b1;
    end
  end

  // Bits that are intentionally dropped (hidden bit, upper exponent bits, unused classes)
  logic unused_bits;
  assign unused_bits = ^{t_sig[NSIG], sub_sig[NSIG], biased[EW-1:NEXP],
                         a_flags[F_SUBNORMAL], a_flags[F_NORMAL],
                         b_flags[F_SUBNORMAL], b_flags[F_NORMAL]};

  // Control FSM, operand datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      a_raw   <= '0;
      b_raw   <= '0;
      a_flags <= '0;
      b_flags <= '0;
      a_exp   <= '0;
      b_exp   <= '0;
      a_sig   <= '0;
      b_sig   <= '0;
      sign_r  <= 1'b0;
      exp_r   <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      qFlags  <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            a_raw   <= a;
            b_raw   <= b;
            a_flags <= classify(a);
            b_flags <= classify(b);
            a_exp   <= unb_exp(a);
            b_exp   <= unb_exp(b);
            a_sig   <= full_sig(a);
            b_sig   <= full_sig(b);
            sign_r  <= a[W-1] ^ b[W-1];
            quo     <= '0;
            busy    <= 1'b1;
            state_r <= S_NORM;
          end
        end
        S_NORM: begin
          if (special_hit) begin
            state_r <= S_FIN;
          end else if (a_sig[NSIG] && b_sig[NSIG]) begin
            exp_r   <= a_exp - b_exp;
            rem     <= {1'b0, a_sig};
            cnt     <= CNT_INIT;
            state_r <= S_DIV;
          end else begin
            // Subnormal operands: shift up one place per cycle, independently
            if (!a_sig[NSIG]) begin
              a_sig <= a_sig << 1;
              a_exp <= a_exp - ONE_E;
            end
            if (!b_sig[NSIG]) begin
              b_sig <= b_sig << 1;
              b_exp <= b_exp - ONE_E;
            end
          end
        end
        S_DIV: begin
          rem <= rem_next << 1;
          quo <= {quo[NSIG:0], ~trial[NSIG+1]};
          cnt <= cnt - CNT_ONE;
          if (cnt == '0) state_r <= S_FIN;
        end
        S_FIN: begin
          q       <= special_hit ? special_q : arith_q;
          qFlags  <= special_hit ? special_flags : arith_flags;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule
